// File: rtl/ctrl_pkg.sv
// Shared control definitions: opcode constants, fetch FSM encodings, word width.
package ctrl_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_WAIT_PC = 3'd3,
        S_HALT    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, beq target or j target.
// Only instr[25:0] matters here (jump index; its low half is the branch offset).
module next_pc_calc
    import ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] pc,
    input  logic [25:0]        instrLow,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic [INSTR_W-1:0] pcPlus4,
    output logic [INSTR_W-1:0] nextPc
);

    logic [INSTR_W-1:0] branch_off;
    logic [INSTR_W-1:0] jump_tgt;

    assign pcPlus4    = pc + 32'd4;
    assign branch_off = {{14{instrLow[15]}}, instrLow[15:0], 2'b00};
    assign jump_tgt   = {pcPlus4[31:28], instrLow, 2'b00};

    // Jump takes priority over a taken branch; everything wraps modulo 2^32.
    always_comb begin
        nextPc = pcPlus4;
        if (jump) begin
            nextPc = jump_tgt;
        end else if (branch && zero) begin
            nextPc = pcPlus4 + branch_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch front end: owns the PC, fetches one word over req/ack,
// holds it in the instruction register until downstream accepts it, then
// waits for the datapath to resolve the next PC.
//
// Handshakes:
//   imem : imemReq stays high (imemAddr stable) until a cycle with imemAck;
//          imemData is taken only in that cycle. Ack outside FETCH is ignored.
//   instr: instrValid stays high (instr stable) until a cycle with instrReady;
//          the word transfers in exactly that cycle.
module instr_fetch_unit
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imemReq,
    output logic [INSTR_W-1:0] imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opCode,
    output logic               instrValid,
    input  logic               instrReady,
    input  logic               pcUpdate,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pcPlus4,
    output logic               fetchErr,
    output fetch_state_e       fetchState
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e       state_q;
    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               req_q;
    logic               err_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [INSTR_W-1:0] next_pc_d;

    next_pc_calc u_next_pc (
        .pc       (pc_q),
        .instrLow (instr_q[25:0]),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .pcPlus4  (pcPlus4),
        .nextPc   (next_pc_d)
    );

    // Fetch FSM with instruction register, PC register and ack timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imemAck) begin
                        instr_q <= imemData;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_HOLD;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    // pcUpdate here is deliberately ignored; it belongs to WAIT_PC.
                    if (instrReady) begin
                        valid_q <= 1'b0;
                        state_q <= S_WAIT_PC;
                    end
                end
                S_WAIT_PC: begin
                    if (pcUpdate) begin
                        pc_q       <= next_pc_d;
                        wait_cnt_q <= '0;
                        req_q      <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    req_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imemReq    = req_q;
    assign imemAddr   = pc_q;
    assign instr      = instr_q;
    assign opCode     = instr_q[31:26];
    assign instrValid = valid_q;
    assign pc         = pc_q;
    assign fetchErr   = err_q;
    assign fetchState = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential/beq/j PC updates,
// backpressure, stray strobes, PC wrap, timeout and reset recovery.
module tb_instr_fetch_unit;
    import ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         imemReq;
    logic [31:0]  imemAddr;
    logic         imemAck;
    logic [31:0]  imemData;
    logic [31:0]  instr;
    logic [5:0]   opCode;
    logic         instrValid;
    logic         instrReady;
    logic         pcUpdate;
    logic         branch;
    logic         jump;
    logic         zero;
    logic [31:0]  pc;
    logic [31:0]  pcPlus4;
    logic         fetchErr;
    fetch_state_e fetchState;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .instr      (instr),
        .opCode     (opCode),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .pcUpdate   (pcUpdate),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .fetchErr   (fetchErr),
        .fetchState (fetchState)
    );

    // clock
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch: DUT must be in FETCH at exp_addr; ack in the first cycle.
    task automatic fetch_word(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        check({tag, "_req"}, 32'(imemReq), 32'd1);
        check({tag, "_addr"}, imemAddr, exp_addr);
        imemAck  = 1'b1;
        imemData = data;
        step();
        imemAck  = 1'b0;
        imemData = 32'h0;
        check({tag, "_valid"}, 32'(instrValid), 32'd1);
        check({tag, "_instr"}, instr, data);
        check({tag, "_req_drop"}, 32'(imemReq), 32'd0);
    endtask

    task automatic accept(input string tag);
        instrReady = 1'b1;
        step();
        instrReady = 1'b0;
        check({tag, "_valid_clr"}, 32'(instrValid), 32'd0);
        check({tag, "_st_wait"}, 32'(fetchState), 32'(S_WAIT_PC));
    endtask

    task automatic update(input string tag, input logic b, input logic j, input logic z,
                          input logic [31:0] exp_pc);
        pcUpdate = 1'b1;
        branch   = b;
        jump     = j;
        zero     = z;
        step();
        pcUpdate = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        zero     = 1'b0;
        check({tag, "_pc"}, imemAddr, exp_pc);
        check({tag, "_req"}, 32'(imemReq), 32'd1);
    endtask

    initial begin
        reset = 1'b1; imemAck = 1'b0; imemData = 32'h0; instrReady = 1'b0;
        pcUpdate = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
        @(negedge clk);
        step();
        step();

        // 1: reset state, then zero-wait fetch of lw
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_err", 32'(fetchErr), 32'd0);
        check("rst_state", 32'(fetchState), 32'(S_IDLE));
        reset = 1'b0;
        step();
        check("t1_st_fetch", 32'(fetchState), 32'(S_FETCH));
        fetch_word("t1", 32'h0, 32'h8C22_0004);
        check("t1_opcode", 32'(opCode), 32'(OP_LW));
        accept("t1");
        update("t1_seq", 1'b0, 1'b0, 1'b0, 32'h4);

        // reach pc=0x10 through j 0x0800_0004
        fetch_word("j10", 32'h4, 32'h0800_0004);
        check("j10_opcode", 32'(opCode), 32'(OP_J));
        accept("j10");
        update("j10", 1'b0, 1'b1, 1'b0, 32'h10);

        // 2: sequential at pc=0x10
        fetch_word("t2", 32'h10, 32'h0000_0020);
        check("t2_pcplus4", pcPlus4, 32'h14);
        accept("t2");
        update("t2", 1'b0, 1'b0, 1'b0, 32'h14);
        fetch_word("back10", 32'h14, 32'h0800_0004);
        accept("back10");
        update("back10", 1'b0, 1'b1, 1'b0, 32'h10);

        // 3: beq taken at 0x10 -> 0x14 + 0xC
        fetch_word("t3", 32'h10, 32'h1022_0003);
        check("t3_opcode", 32'(opCode), 32'(OP_BEQ));
        accept("t3");
        update("t3_taken", 1'b1, 1'b0, 1'b1, 32'h20);

        // 4: j with branch also set, jump wins
        fetch_word("t4", 32'h20, 32'h0800_0040);
        accept("t4");
        update("t4_jump", 1'b1, 1'b1, 1'b1, 32'h100);

        // 3b: same beq with zero=0 falls through
        fetch_word("to10", 32'h100, 32'h0800_0004);
        accept("to10");
        update("to10", 1'b0, 1'b1, 1'b0, 32'h10);
        fetch_word("t3b", 32'h10, 32'h1022_0003);
        accept("t3b");
        update("t3b_nottaken", 1'b1, 1'b0, 1'b0, 32'h14);

        // backward beq: offset -5 words from 0x18 -> 0x04
        fetch_word("bwd", 32'h14, 32'h1000_FFFB);
        accept("bwd");
        update("bwd", 1'b1, 1'b0, 1'b1, 32'h4);

        // 5: backpressure for 5 cycles with stray ack and pcUpdate
        fetch_word("t5", 32'h4, 32'hAC22_0008);
        check("t5_opcode", 32'(opCode), 32'(OP_SW));
        for (int i = 0; i < 5; i++) begin
            imemAck  = 1'b1;
            imemData = 32'hDEAD_BEEF;
            pcUpdate = 1'b1;
            jump     = 1'b1;
            step();
            check("t5_hold_instr", instr, 32'hAC22_0008);
            check("t5_hold_valid", 32'(instrValid), 32'd1);
            check("t5_hold_pc", pc, 32'h4);
            check("t5_hold_req", 32'(imemReq), 32'd0);
        end
        imemAck = 1'b0; imemData = 32'h0;
        // acceptance cycle with pcUpdate still high: the strobe must be ignored
        instrReady = 1'b1;
        step();
        instrReady = 1'b0; pcUpdate = 1'b0; jump = 1'b0;
        check("t5_acc_state", 32'(fetchState), 32'(S_WAIT_PC));
        check("t5_acc_pc", pc, 32'h4);
        update("t5_seq", 1'b0, 1'b0, 1'b0, 32'h8);

        // wrap: beq -4 words from 0x0C -> 0xFFFF_FFFC, then pcPlus4 wraps to 0
        fetch_word("wrap", 32'h8, 32'h1000_FFFC);
        accept("wrap");
        update("wrap", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pcplus4", pcPlus4, 32'h0);
        fetch_word("wrapf", 32'hFFFF_FFFC, 32'h0000_0000);
        accept("wrapf");
        update("wrapf", 1'b0, 1'b0, 1'b0, 32'h0);

        // 6: timeout - 16 FETCH cycles without ack
        for (int i = 0; i < 15; i++) step();
        check("t6_pre_err", 32'(fetchErr), 32'd0);
        check("t6_pre_req", 32'(imemReq), 32'd1);
        step();
        check("t6_err", 32'(fetchErr), 32'd1);
        check("t6_req", 32'(imemReq), 32'd0);
        check("t6_state", 32'(fetchState), 32'(S_HALT));
        for (int i = 0; i < 3; i++) begin
            imemAck  = 1'b1;
            imemData = 32'h1234_5678;
            pcUpdate = 1'b1;
            step();
            check("t6_frozen_err", 32'(fetchErr), 32'd1);
            check("t6_frozen_req", 32'(imemReq), 32'd0);
            check("t6_frozen_instr", instr, 32'h0);
            check("t6_frozen_pc", pc, 32'h0);
        end
        pcUpdate = 1'b0;

        // reset with ack held high through reset and IDLE
        reset = 1'b1;
        step();
        check("t6_rst_err", 32'(fetchErr), 32'd0);
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_state", 32'(fetchState), 32'(S_IDLE));
        reset = 1'b0;
        step();
        check("t6_idle_ack_valid", 32'(instrValid), 32'd0);
        check("t6_idle_ack_instr", instr, 32'h0);
        check("t6_idle_ack_req", 32'(imemReq), 32'd1);
        imemAck = 1'b0;

        // reset mid-fetch: request drops, in-flight word discarded
        imemAck  = 1'b1;
        imemData = 32'hCAFE_0000;
        reset    = 1'b1;
        step();
        check("midrst_req", 32'(imemReq), 32'd0);
        check("midrst_valid", 32'(instrValid), 32'd0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_pc", pc, 32'h0);
        imemAck = 1'b0;
        reset   = 1'b0;
        step();
        fetch_word("post", 32'h0, 32'h8C22_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=stalled expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
